// File: rtl/demux_pkg.sv
// Shared widths and types for the 1-to-8 demultiplexer.
package demux_pkg;

  localparam int N_OUT = 8;
  localparam int SEL_W = 3;

  typedef logic [N_OUT-1:0] onehot_t;

endpackage : demux_pkg

// File: rtl/demux_1_decoder_3to8.sv
// 3-to-8 one-hot decoder: sel[N] is high exactly when s == N.
module decoder_3to8
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] s,
  output onehot_t          sel
);

  // Compare the select against every output index.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_OUT; i++) begin
      sel[i] = (s == SEL_W'(i));
    end
  end

endmodule : decoder_3to8

// File: rtl/demux_1.sv
// Registered (or optionally combinational) 1-to-8 demultiplexer.
// The selected output carries d; all other outputs are held at 0.
module demux_1
  import demux_pkg::*;
#(
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  input  logic [SEL_W-1:0] s,
  output logic             y0,
  output logic             y1,
  output logic             y2,
  output logic             y3,
  output logic             y4,
  output logic             y5,
  output logic             y6,
  output logic             y7
);

  onehot_t sel;
  onehot_t y_d;
  onehot_t y_bus;

  decoder_3to8 u_dec (
    .s   (s),
    .sel (sel)
  );

  // Gate the one-hot select with the data bit.
  assign y_d = sel & {N_OUT{d}};

  if (REGISTERED) begin : g_reg
    onehot_t y_q;

    // Output flops: cleared asynchronously, reloaded on every edge (no enable).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        y_q <= '0;
      end else begin
        y_q <= y_d;
      end
    end

    assign y_bus = y_q;
  end else begin : g_comb
    // Pure decode path; clk and rst_n play no part here.
    assign y_bus = y_d;
  end

  assign y0 = y_bus[0];
  assign y1 = y_bus[1];
  assign y2 = y_bus[2];
  assign y3 = y_bus[3];
  assign y4 = y_bus[4];
  assign y5 = y_bus[5];
  assign y6 = y_bus[6];
  assign y7 = y_bus[7];

endmodule : demux_1

// File: tb/tb_demux_1.sv
// Directed bench for demux_1: registered instance plus a combinational instance.
module tb_demux_1;

  logic       clk;
  logic       rst_n;
  logic       d;
  logic [2:0] s;
  logic       y0, y1, y2, y3, y4, y5, y6, y7;

  logic       clk_c;
  logic       rst_c;
  logic       d_c;
  logic [2:0] s_c;
  logic       c0, c1, c2, c3, c4, c5, c6, c7;

  logic [7:0] exp_q[$];
  int         n_cmp;
  int         n_fail;

  demux_1 #(.REGISTERED(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .d(d), .s(s),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .y4(y4), .y5(y5), .y6(y6), .y7(y7)
  );

  demux_1 #(.REGISTERED(1'b0)) dut_c (
    .clk(clk_c), .rst_n(rst_c), .d(d_c), .s(s_c),
    .y0(c0), .y1(c1), .y2(c2), .y3(c3),
    .y4(c4), .y5(c5), .y6(c6), .y7(c7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic dv, input logic [2:0] sv);
    logic [7:0] v;
    v = 8'h00;
    if (dv) v[sv] = 1'b1;
    return v;
  endfunction

  // Pop the oldest expected value and compare it against the chosen instance.
  task automatic check(input string tag, input bit comb);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = comb ? {c7, c6, c5, c4, c3, c2, c1, c0}
               : {y7, y6, y5, y4, y3, y2, y1, y0};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %b, expected value missing from scoreboard", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
    end
  endtask

  // Drive one input pair between edges, then check one cycle later.
  task automatic cycle(input logic dv, input logic [2:0] sv, input string tag);
    @(negedge clk);
    d = dv;
    s = sv;
    exp_q.push_back(model(dv, sv));
    @(posedge clk);
    #1;
    check(tag, 1'b0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    d      = 1'b1;
    s      = 3'd3;
    clk_c  = 1'b0;
    rst_c  = 1'b1;
    d_c    = 1'b0;
    s_c    = 3'd0;

    // Reset held with a live selection: outputs stay 0 across edges.
    #1;
    exp_q.push_back(8'h00);
    check("rst_hold0", 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back(8'h00);
      check($sformatf("rst_hold%0d", i + 1), 1'b0);
    end

    // Release reset: y3 appears after the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model(1'b1, 3'd3));
    @(posedge clk);
    #1;
    check("rst_release", 1'b0);

    // Sweep select with d = 1.
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), $sformatf("sweep_s%0d", i));

    // Data gating: d = 0 keeps everything low.
    for (int i = 0; i < 8; i++) cycle(1'b0, 3'(i), $sformatf("gate_s%0d", i));
    cycle(1'b1, 3'd5, "gate_s5_on");

    // Wrap 7 -> 0, then simultaneous select/data change.
    cycle(1'b1, 3'd7, "wrap_s7");
    cycle(1'b1, 3'd0, "wrap_s0");
    cycle(1'b0, 3'd2, "simul_s2_d0");

    // Async reset between edges must clear y6 before the next edge.
    cycle(1'b1, 3'd6, "pre_async_s6");
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(8'h00);
    check("async_rst_now", 1'b0);
    @(posedge clk);
    #1;
    exp_q.push_back(8'h00);
    check("async_rst_edge", 1'b0);

    // First edge after release loads normally.
    @(negedge clk);
    rst_n = 1'b1;
    d = 1'b1;
    s = 3'd1;
    exp_q.push_back(model(1'b1, 3'd1));
    @(posedge clk);
    #1;
    check("post_async_s1", 1'b0);

    // Combinational instance: no clock, reset toggled and ignored.
    d_c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_c   = 3'(i);
      rst_c = (i % 2 == 0);
      exp_q.push_back(model(1'b1, 3'(i)));
      #1;
      check($sformatf("comb_s%0d", i), 1'b1);
    end
    d_c   = 1'b0;
    s_c   = 3'd4;
    rst_c = 1'b0;
    exp_q.push_back(8'h00);
    #1;
    check("comb_d0", 1'b1);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_demux_1
